mc14500_sequencer: RTL and testbench

//   Program sequencer at the far end of the ICU control outputs. Holds the

---
 rtl/mc14500_sequencer.sv | 154 +++++++++++++++
 tb/tb_mc14500_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc14500_sequencer.sv
// MC14500 program sequencer: PC, return stack, halt/step control.
// Splits program words into ICU opcode and I/O address.
package mc14500_pkg;
  typedef enum logic [3:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } instruction_t;
endpackage

module mc14500_sequencer
  import mc14500_pkg::*;
#(
  parameter int PC_W        = 8,
  parameter int OPERAND_W   = 8,
  parameter int STACK_DEPTH = 4,
  localparam int LVL_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_W-1:0]        prog_addr,
  input  logic [OPERAND_W+3:0]   prog_data,
  output instruction_t           instruction,
  output logic [OPERAND_W-1:0]   io_addr,
  input  logic                   jmp,
  input  logic                   rtn,
  input  logic                   flag_f,
  input  logic                   run,
  input  logic                   step,
  output logic                   halted,
  output logic [LVL_W-1:0]       stack_level,
  output logic                   stack_err
);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_STEP
  } state_t;

  state_t state, state_nxt;

  logic [PC_W-1:0]      pc, pc_inc, pc_nxt;
  logic [PC_W-1:0]      stack [STACK_DEPTH];
  logic [LVL_W-1:0]     level, level_nxt;
  logic                 err;
  logic                 push, pop, err_set;
  logic                 exec, empty, full;
  logic [OPERAND_W-1:0] operand;
  logic [3:0]           opcode;

  assign operand = prog_data[OPERAND_W-1:0];
  assign opcode  = prog_data[OPERAND_W+3 -: 4];
  assign exec    = state != S_HALT;
  assign empty   = level == '0;
  assign full    = level == LVL_W'(STACK_DEPTH);
  assign pc_inc  = pc + PC_W'(1);

  // rtn outranks jmp so an illegal jmp+rtn never pushes
  always_comb begin
    pc_nxt  = pc;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    if (exec) begin
      if (rtn) begin
        if (!empty) begin
          pc_nxt = stack[0];
          pop    = 1'b1;
        end else begin
          pc_nxt  = pc_inc;
          err_set = 1'b1;
        end
      end else if (jmp) begin
        pc_nxt = operand[PC_W-1:0];
        if (!full) push = 1'b1;
        else err_set = 1'b1;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_comb begin
    level_nxt = level;
    if (push) level_nxt = level + LVL_W'(1);
    else if (pop) level_nxt = level - LVL_W'(1);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RUN:   if (flag_f) state_nxt = S_HALT;
      S_HALT: begin
        if (run) state_nxt = S_RUN;
        else if (step) state_nxt = S_STEP;
      end
      S_STEP:  state_nxt = S_HALT;
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_RUN;
      pc    <= '0;
      level <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      level <= level_nxt;
      if (err_set) err <= 1'b1;
    end
  end

  // Shift-register stack: top of stack is always entry 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STACK_DEPTH; i++)
        stack[i] <= '0;
    end else if (push) begin
      stack[0] <= pc_inc;
      for (int i = 1; i < STACK_DEPTH; i++)
        stack[i] <= stack[i-1];
    end else if (pop) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++)
        stack[i] <= stack[i+1];
      stack[STACK_DEPTH-1] <= '0;
    end
  end

  assign prog_addr   = pc;
  assign instruction = (state == S_HALT) ? OP_NOPO
                                         : instruction_t'(opcode);
  assign io_addr     = operand;
  assign halted      = state != S_RUN;
  assign stack_level = level;
  assign stack_err   = err;

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Scoreboard bench for mc14500_sequencer: queue-based reference model,
// directed program scenarios plus randomized programs and controls.
module tb_mc14500_sequencer;
  import mc14500_pkg::*;

  localparam int DEPTH = 4;
  localparam int M_RUN  = 0;
  localparam int M_HALT = 1;
  localparam int M_STEP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [7:0]   prog_addr;
  logic [11:0]  prog_data;
  instruction_t instruction;
  logic [7:0]   io_addr;
  logic         jmp = 1'b0;
  logic         rtn = 1'b0;
  logic         flag_f = 1'b0;
  logic         run = 1'b0;
  logic         step = 1'b0;
  logic         halted;
  logic [2:0]   stack_level;
  logic         stack_err;

  logic [11:0] mem [256];

  mc14500_sequencer #(
    .PC_W(8),
    .OPERAND_W(8),
    .STACK_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .instruction(instruction),
    .io_addr(io_addr),
    .jmp(jmp),
    .rtn(rtn),
    .flag_f(flag_f),
    .run(run),
    .step(step),
    .halted(halted),
    .stack_level(stack_level),
    .stack_err(stack_err)
  );

  assign prog_data = mem[prog_addr];

  always #5 clk = ~clk;

  typedef struct {
    int pc;
    int halted;
    int level;
    int err;
    int instr;
    int io;
  } exp_t;

  exp_t exp_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  int m_pc;
  int m_stk[$];
  int m_mode;
  bit m_err;
  bit m_skip;

  function automatic void chk(string nm, int act, int want);
    n_chk++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  nm, act, want, $time);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("prog_addr", int'(prog_addr), e.pc);
      chk("halted", int'(halted), e.halted);
      chk("stack_level", int'(stack_level), e.level);
      chk("stack_err", int'(stack_err), e.err);
      chk("instruction", int'(instruction), e.instr);
      chk("io_addr", int'(io_addr), e.io);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    {jmp, rtn, flag_f, run, step} = '0;
    #1;
    chk("rst prog_addr", int'(prog_addr), 0);
    chk("rst halted", int'(halted), 0);
    chk("rst stack_level", int'(stack_level), 0);
    chk("rst stack_err", int'(stack_err), 0);
    m_pc = 0;
    m_stk.delete();
    m_mode = M_RUN;
    m_err = 1'b0;
    m_skip = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill_ld();
    for (int i = 0; i < 256; i++)
      mem[i] = {4'h1, 8'($urandom)};
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++)
      mem[i] = 12'($urandom);
  endtask

  // raw: controls drawn at random instead of from the opcode
  task automatic tick(input bit run_v, input bit step_v,
                      input bit raw, input bit skz_take);
    logic [11:0] w;
    logic [3:0]  op;
    bit ex, act, j, r, f;
    exp_t e;
    @(negedge clk);
    #1;
    w  = mem[m_pc];
    op = w[11:8];
    ex = m_mode != M_HALT;
    if (raw) begin
      j = ex && ($urandom_range(0, 3) == 0);
      r = ex && ($urandom_range(0, 5) == 0);
      f = ex && ($urandom_range(0, 9) == 0);
      m_skip = 1'b0;
    end else begin
      act = ex && !m_skip;
      j = act && op == OP_JMP;
      r = act && op == OP_RTN;
      f = act && op == OP_NOPF;
      m_skip = ex && (r || (act && op == OP_SKZ && skz_take));
    end
    jmp = j;
    rtn = r;
    flag_f = f;
    run = run_v;
    step = step_v;
    if (m_mode == M_HALT) begin
      if (run_v) m_mode = M_RUN;
      else if (step_v) m_mode = M_STEP;
    end else begin
      if (r) begin
        if (m_stk.size() > 0) begin
          m_pc = m_stk.pop_front();
        end else begin
          m_pc = (m_pc + 1) % 256;
          m_err = 1'b1;
        end
      end else if (j) begin
        if (m_stk.size() < DEPTH) m_stk.push_front((m_pc + 1) % 256);
        else m_err = 1'b1;
        m_pc = int'(w[7:0]);
      end else begin
        m_pc = (m_pc + 1) % 256;
      end
      if (m_mode == M_STEP) m_mode = M_HALT;
      else if (f) m_mode = M_HALT;
    end
    @(posedge clk);
    e.pc = m_pc;
    e.halted = (m_mode != M_RUN) ? 1 : 0;
    e.level = m_stk.size();
    e.err = int'(m_err);
    e.instr = (m_mode == M_HALT) ? 0 : int'(mem[m_pc][11:8]);
    e.io = int'(mem[m_pc][7:0]);
    exp_q.push_back(e);
  endtask

  task automatic run_n(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // plain sequential words
    do_reset();
    fill_ld();
    run_n(4);

    // call and return
    do_reset();
    fill_ld();
    mem[8'h02] = {OP_JMP, 8'h10};
    mem[8'h03] = {OP_NOPO, 8'h00};
    mem[8'h12] = {OP_RTN, 8'h00};
    run_n(8);

    // stack overflow with 5 nested calls, then a return
    do_reset();
    fill_ld();
    mem[8'h00] = {OP_JMP, 8'h10};
    mem[8'h10] = {OP_JMP, 8'h20};
    mem[8'h20] = {OP_JMP, 8'h30};
    mem[8'h30] = {OP_JMP, 8'h40};
    mem[8'h40] = {OP_JMP, 8'h50};
    mem[8'h50] = {OP_RTN, 8'h00};
    run_n(8);

    // underflow
    do_reset();
    fill_ld();
    mem[8'h00] = {OP_RTN, 8'h00};
    run_n(3);

    // halt, hold, single step, then run+step
    do_reset();
    fill_ld();
    mem[8'h05] = {OP_NOPF, 8'h00};
    run_n(6);
    run_n(10);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    run_n(2);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    run_n(4);

    // PC wrap
    do_reset();
    fill_ld();
    mem[8'h00] = {OP_JMP, 8'hFE};
    run_n(4);

    // SKZ-skipped JMP
    do_reset();
    fill_ld();
    mem[8'h00] = {OP_JMP, 8'h1F};
    mem[8'h1F] = {OP_SKZ, 8'h00};
    mem[8'h20] = {OP_JMP, 8'h40};
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    run_n(3);

    // level 2, sticky error, halted; then reset mid-halt
    do_reset();
    fill_ld();
    mem[8'h00] = {OP_RTN, 8'h00};
    mem[8'h02] = {OP_JMP, 8'h10};
    mem[8'h03] = {OP_NOPO, 8'h00};
    mem[8'h10] = {OP_JMP, 8'h20};
    mem[8'h11] = {OP_NOPO, 8'h00};
    mem[8'h20] = {OP_NOPF, 8'h00};
    run_n(8);

    // randomized programs and controls
    repeat (4) begin
      do_reset();
      fill_rand();
      repeat (600)
        tick($urandom_range(0, 5) == 0,
             $urandom_range(0, 3) == 0,
             $urandom_range(0, 9) == 0,
             1'($urandom));
    end

    repeat (2) @(negedge clk);
    #2;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
